fb_fill: RTL
============

# fb_fill

Rectangle-fill engine: the write-side counterpart to the read-only multi-port video RAM. It accepts one rectangle command at a time over a valid/ready handshake. It clips the rectangle to the framebuffer bounds, then rasterises it row-major into a single framebuffer write port, one pixel per accepted beat. The game logic uses it to clear the screen and paint the track, obstacle and HUD rectangles before the display readers fetch pixels.

## Interface
- FB_W, 160: framebuffer width in pixels.
- FB_H, 120: framebuffer height in pixels.
- WIDTH, 12: pixel width in bits.
- Derived: XW = $clog2(FB_W), YW = $clog2(FB_H), AWIDTH = $clog2(FB_W*FB_H).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_x  in  XW  left column.
- cmd_y  in  YW  top row.
- cmd_w  in  XW+1  width in pixels.
- cmd_h  in  YW+1  height in pixels.
- cmd_color  in  WIDTH  primary colour.
- cmd_color2  in  WIDTH  secondary colour (checker mode only).
- cmd_pattern  in  1  1 = checkerboard (checker mode only).
- wr_en  out  1  write request.
- wr_ready  in  1  the framebuffer accepts the write this cycle.
- wr_addr  out  AWIDTH  linear address, y*FB_W + x.
- wr_data  out  WIDTH  pixel value.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, SETUP, RUN.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register all cmd_* fields and go to SETUP.
- SETUP computes the clip with 1-bit-widened arithmetic:
  - x_end = min(cmd_x + cmd_w, FB_W); y_end = min(cmd_y + cmd_h, FB_H).
  - The rectangle is empty if cmd_w == 0, cmd_h == 0, cmd_x >= FB_W or cmd_y >= FB_H.
  - Empty: go to IDLE and pulse done. No write is issued.
  - Otherwise: set row_base = cmd_y*FB_W, x = cmd_x, y = cmd_y, and go to RUN.
  - The multiply is allowed in SETUP only.
- RUN:
  - wr_en = 1, wr_addr = row_base + x.
  - On each beat with wr_en && wr_ready, x increments.
  - When x reaches x_end-1 on an accepted beat: x = cmd_x, y increments, row_base += FB_W. No multiplier is used in RUN.
  - When the last pixel (x_end-1, y_end-1) is accepted, go to IDLE and pulse done.
- While wr_ready = 0: wr_en, wr_addr and wr_data hold. No address is skipped or repeated.
- busy = (state != IDLE).
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, and cmd_ready 1 once rst is low.
- Reset mid-command:
  - All outputs return to their reset values asynchronously.
  - The command is discarded and never resumed.
  - done does not pulse.

## Timing
- Command handshake at cycle T. SETUP runs at T+1. The first wr_en is at T+2.
- Without stalls, writes occupy T+2 .. T+1+N, where N is the clipped pixel count. done is high at T+2+N.
- Empty command: done at T+2.
- done coincides with the return to IDLE, so cmd_ready = 1 in the same cycle. A new command may be accepted in the done cycle.
- wr_data, wr_addr and wr_en are registered outputs.

## Configuration
- Macro: FB_FILL_CHECKER_EN.
- Defined: when cmd_pattern = 1, wr_data = ((x ^ y) & 1) ? cmd_color2 : cmd_color. The x and y here are absolute framebuffer coordinates.
- Not defined: cmd_color2 and cmd_pattern are present but ignored, and wr_data = cmd_color always.
- Handshake timing and addresses are identical in both configurations.

## Structure
- Shared package fb_pkg holds:
  - FB_W, FB_H and WIDTH defaults;
  - pixel_t and fb_addr_t typedefs;
  - the fill_state_e enum (IDLE, SETUP, RUN).
- One sub-module is natural: fb_clip, a combinational clip and empty detection instantiated by SETUP.
- Counters, row_base and the FSM stay in fb_fill.

## Test plan
1. Basic fill: x=2, y=3, w=2, h=2, colour 0xF00, wr_ready tied high.
   - Writes to 482, 483, 642, 643 on T+2..T+5, all with data 0xF00.
   - done at T+6.
2. Clipping: x=158, y=119, w=5, h=5.
   - Exactly two writes, to 19198 and 19199.
   - done at T+4.
3. Empty command: w=0, h=7.
   - No wr_en.
   - done at T+2; busy is high only at T+1.
4. Stall: a 3×1 fill with wr_ready low for 3 cycles after the first accepted beat.
   - wr_addr and wr_data held while stalled.
   - Addresses accepted in order with no repeats.
   - done 1 cycle after the last accepted beat.
5. Reset mid-fill: assert rst during RUN.
   - wr_en, busy and done go to 0 immediately.
   - After release, cmd_ready = 1 and a new fill at x=0, y=0, w=1, h=1 writes address 0.
6. Checker (with FB_FILL_CHECKER_EN): x=0, y=0, w=2, h=2, colour 0x0F0, colour2 0x00F, pattern 1.
   - Expected data: addr 0 = 0x0F0, addr 1 = 0x00F, addr 160 = 0x00F, addr 161 = 0x0F0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer write side.
//   DEF_FB_W / DEF_FB_H / DEF_WIDTH : default framebuffer geometry and pixel width
//   pixel_t, fb_addr_t              : pixel and linear-address types at the defaults
//   fill_state_e                    : rectangle-fill engine states (IDLE, SETUP, RUN)
package fb_pkg;

    localparam int DEF_FB_W   = 160;
    localparam int DEF_FB_H   = 120;
    localparam int DEF_WIDTH  = 12;
    localparam int DEF_AWIDTH = $clog2(DEF_FB_W * DEF_FB_H);

    typedef logic [DEF_WIDTH-1:0]  pixel_t;
    typedef logic [DEF_AWIDTH-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } fill_state_e;

endpackage

// File: rtl/fb_clip.sv
// fb_clip: combinational clip of a rectangle command against the framebuffer.
//   x, y      : top-left corner of the requested rectangle
//   w, h      : requested width / height in pixels
//   x_end     : exclusive right bound, min(x + w, FB_W)
//   y_end     : exclusive bottom bound, min(y + h, FB_H)
//   empty     : nothing to draw (zero size or origin outside the framebuffer)
module fb_clip
    import fb_pkg::*;
#(
    parameter int  FB_W = DEF_FB_W,
    parameter int  FB_H = DEF_FB_H,
    localparam int XW   = $clog2(FB_W),
    localparam int YW   = $clog2(FB_H)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    output logic [XW:0]   x_end,
    output logic [YW:0]   y_end,
    output logic          empty
);

    // Sums carry one extra bit so x + w can never wrap before the compare.
    logic [XW+1:0] x_sum_s;
    logic [YW+1:0] y_sum_s;

    assign x_sum_s = {2'b00, x} + {1'b0, w};
    assign y_sum_s = {2'b00, y} + {1'b0, h};

    assign x_end = (x_sum_s > (XW+2)'(FB_W)) ? (XW+1)'(FB_W) : x_sum_s[XW:0];
    assign y_end = (y_sum_s > (YW+2)'(FB_H)) ? (YW+1)'(FB_H) : y_sum_s[YW:0];

    assign empty = (w == {(XW+1){1'b0}}) ||
                   (h == {(YW+1){1'b0}}) ||
                   ({1'b0, x} >= (XW+1)'(FB_W)) ||
                   ({1'b0, y} >= (YW+1)'(FB_H));

endmodule

// File: rtl/fb_fill.sv
// fb_fill: rectangle-fill engine. Accepts one command over valid/ready, clips it
// to the framebuffer, then writes it row-major, one pixel per accepted beat.
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (ready while idle)
//   cmd_x, cmd_y             : top-left corner
//   cmd_w, cmd_h             : size in pixels
//   cmd_color, cmd_color2    : primary / secondary colour
//   cmd_pattern              : checkerboard select
//   wr_en / wr_ready         : write request / framebuffer accept
//   wr_addr, wr_data         : linear address y*FB_W + x, pixel value
//   busy                     : a command is in progress
//   done                     : one-cycle pulse when a command completes
// Build option: FB_FILL_CHECKER_EN enables the checkerboard pattern
// (cmd_color2 on odd x^y cells when cmd_pattern = 1); without it the secondary
// colour and pattern inputs are ignored and every pixel is cmd_color.
module fb_fill
    import fb_pkg::*;
#(
    parameter int  FB_W   = DEF_FB_W,
    parameter int  FB_H   = DEF_FB_H,
    parameter int  WIDTH  = DEF_WIDTH,
    localparam int XW     = $clog2(FB_W),
    localparam int YW     = $clog2(FB_H),
    localparam int AWIDTH = $clog2(FB_W * FB_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [XW-1:0]     cmd_x,
    input  logic [YW-1:0]     cmd_y,
    input  logic [XW:0]       cmd_w,
    input  logic [YW:0]       cmd_h,
    input  logic [WIDTH-1:0]  cmd_color,
    input  logic [WIDTH-1:0]  cmd_color2,
    input  logic              cmd_pattern,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done
);

    fill_state_e state_r, state_n;

    // Captured command
    logic [XW-1:0]    cx_r;
    logic [YW-1:0]    cy_r;
    logic [XW:0]      cw_r;
    logic [YW:0]      ch_r;
    logic [WIDTH-1:0] color_r;
`ifdef FB_FILL_CHECKER_EN
    logic [WIDTH-1:0] color2_r;
    logic             pattern_r;
`else
    logic             unused_s;
    assign unused_s = ^{cmd_color2, cmd_pattern};
`endif

    // Clip results (stable for the whole command since the capture is frozen)
    logic [XW:0] x_end_s;
    logic [YW:0] y_end_s;
    logic        empty_s;

    // Raster position of the pixel currently presented on the write port
    logic [XW-1:0]     x_r, x_n;
    logic [YW-1:0]     y_r, y_n;
    logic [AWIDTH-1:0] row_base_r, row_base_n;

    // Position of the next pixel to present
    logic [XW-1:0]     step_x_s;
    logic [YW-1:0]     step_y_s;
    logic [AWIDTH-1:0] step_base_s;
    logic [AWIDTH-1:0] step_addr_s;
    logic [WIDTH-1:0]  step_pix_s;
    logic [AWIDTH-1:0] setup_base_s;

    logic last_col_s, last_row_s, beat_s;

    logic              wr_en_n;
    logic [AWIDTH-1:0] wr_addr_n;
    logic [WIDTH-1:0]  wr_data_n;
    logic              done_n;

    fb_clip #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_clip (
        .x     (cx_r),
        .y     (cy_r),
        .w     (cw_r),
        .h     (ch_r),
        .x_end (x_end_s),
        .y_end (y_end_s),
        .empty (empty_s)
    );

    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign beat_s    = wr_en && wr_ready;

    assign last_col_s = (({1'b0, x_r} + 1'b1) == x_end_s);
    assign last_row_s = (({1'b0, y_r} + 1'b1) == y_end_s);

    // The only multiply; its result is consumed in SETUP alone, RUN steps rows by addition.
    assign setup_base_s = AWIDTH'(cy_r) * AWIDTH'(FB_W);

    // Next raster position: the rectangle origin in SETUP, otherwise one step forward with row wrap.
    always_comb begin
        step_x_s    = x_r;
        step_y_s    = y_r;
        step_base_s = row_base_r;
        if (state_r == SETUP) begin
            step_x_s    = cx_r;
            step_y_s    = cy_r;
            step_base_s = setup_base_s;
        end else if (last_col_s) begin
            step_x_s    = cx_r;
            step_y_s    = y_r + 1'b1;
            step_base_s = row_base_r + AWIDTH'(FB_W);
        end else begin
            step_x_s    = x_r + 1'b1;
        end
    end

    assign step_addr_s = step_base_s + AWIDTH'(step_x_s);

`ifdef FB_FILL_CHECKER_EN
    assign step_pix_s = (pattern_r && (step_x_s[0] ^ step_y_s[0])) ? color2_r : color_r;
`else
    assign step_pix_s = color_r;
`endif

    // Command capture on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_r      <= {XW{1'b0}};
            cy_r      <= {YW{1'b0}};
            cw_r      <= {(XW+1){1'b0}};
            ch_r      <= {(YW+1){1'b0}};
            color_r   <= {WIDTH{1'b0}};
`ifdef FB_FILL_CHECKER_EN
            color2_r  <= {WIDTH{1'b0}};
            pattern_r <= 1'b0;
`endif
        end else if (cmd_valid && cmd_ready) begin
            cx_r      <= cmd_x;
            cy_r      <= cmd_y;
            cw_r      <= cmd_w;
            ch_r      <= cmd_h;
            color_r   <= cmd_color;
`ifdef FB_FILL_CHECKER_EN
            color2_r  <= cmd_color2;
            pattern_r <= cmd_pattern;
`endif
        end
    end

    // FSM next state, raster counters and next values of the registered write port.
    always_comb begin
        state_n    = state_r;
        x_n        = x_r;
        y_n        = y_r;
        row_base_n = row_base_r;
        wr_en_n    = wr_en;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        done_n     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = SETUP;
                end else begin
                    state_n = IDLE;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n    = RUN;
                    x_n        = step_x_s;
                    y_n        = step_y_s;
                    row_base_n = step_base_s;
                    wr_en_n    = 1'b1;
                    wr_addr_n  = step_addr_s;
                    wr_data_n  = step_pix_s;
                end
            end
            RUN: begin
                if (beat_s && last_col_s && last_row_s) begin
                    state_n = IDLE;
                    wr_en_n = 1'b0;
                    done_n  = 1'b1;
                end else if (beat_s) begin
                    x_n        = step_x_s;
                    y_n        = step_y_s;
                    row_base_n = step_base_s;
                    wr_addr_n  = step_addr_s;
                    wr_data_n  = step_pix_s;
                end else begin
                    // Stalled: everything holds so no address is skipped or repeated.
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
                wr_en_n = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            row_base_r <= {AWIDTH{1'b0}};
            wr_en      <= 1'b0;
            wr_addr    <= {AWIDTH{1'b0}};
            wr_data    <= {WIDTH{1'b0}};
            done       <= 1'b0;
        end else begin
            state_r    <= state_n;
            x_r        <= x_n;
            y_r        <= y_n;
            row_base_r <= row_base_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            done       <= done_n;
        end
    end

endmodule
